datapath_controller: RTL and testbench
======================================

// Module: datapath_controller
// PURPOSE
//  Multi-cycle Moore FSM that sequences the 16-bit register/ALU datapath.
//  Latches one instruction per start handshake and steps the datapath through its phases.
//  Phases: read A, read B, ALU, write-back.
//  Drives every datapath control input and reports busy/done/illegal to the fetch/test harness.
// PARAMETERS
//  DATA_W      16  datapath word width (datapath_in width)
//  REG_ADDR_W  3   register-file index width (8 registers)
// PORTS
//  clk          in   1        rising-edge clock, single clock domain
//  reset_n      in   1        asynchronous, active-low reset
//  start        in   1        request: instr valid, sampled only in WAIT
//  instr        in   16       instruction word
//  busy         out  1        high in every state except WAIT
//  done         out  1        one-cycle pulse on return to WAIT
//  illegal      out  1        one-cycle pulse with done for an undefined opcode
//  write        out  1        regfile write enable
//  vsel         out  1        1: write datapath_in, 0: write datapath_out
//  loada/loadb  out  1 each   load A/B pipeline register
//  loadc/loads  out  1 each   load C result register / Z status flag
//  asel/bsel    out  1 each   1: A operand = 0 / B operand = imm5
//  readnum      out  3        regfile read index
//  writenum     out  3        regfile write index
//  shift        out  2        shifter op = instr[4:3]
//  ALUop        out  2        ALU op
//  datapath_in  out  16       sign-extended imm8 = {{8{ir[7]}}, ir[7:0]}
// BEHAVIOUR
//  Encoding: opc=[15:13] op=[12:11] Rn=[10:8] Rd=[7:5] sh=[4:3] Rm=[2:0].
//  Legal: 110/10 MOV Rn,#imm8 | 110/00 MOV Rd,Rm,sh | 101/op: ALU (op 00 ADD, 01 CMP, 10 AND, 11 MVN).
//  Everything else is illegal.
//  Handshake:
//   - In WAIT, start=1 latches instr into ir at the edge; the next state is DECODE.
//   - start is ignored while busy.
//  States and transitions:
//   - WAIT -> DECODE.
//   - DECODE -> WR_IMM (MOV imm) | GET_B (MOV reg, MVN) | GET_A (ADD/CMP/AND) | WAIT (illegal).
//   - GET_A -> GET_B -> ALU.
//   - ALU -> WR_REG, or WAIT for CMP.
//   - WR_REG / WR_IMM -> WAIT.
//  State outputs (all outputs Moore: decoded from state plus ir, glitch-free):
//   - GET_A:  readnum=Rn, loada=1.
//   - GET_B:  readnum=Rm, loadb=1.
//   - ALU:    loadc=1; loads=1 for CMP only.
//   - WR_REG: write=1, vsel=0, writenum=Rd.
//   - WR_IMM: write=1, vsel=1, writenum=Rn.
//  Every control not listed for a state is 0, except the static outputs below.
//  Static outputs, held from ir in all states:
//   - shift=sh; 00 for MOV imm.
//   - ALUop=op for opcode 101, 00 otherwise.
//   - asel=1 for MOV reg and MVN, else 0.
//   - bsel=0.
//   - datapath_in=sximm8.
//   - readnum=Rm outside GET_A.
//  done and illegal:
//   - done is registered: high in the first WAIT cycle after completion.
//   - illegal pulses together with done when DECODE detects a bad opcode.
//   - An illegal instruction causes no load/write pulses.
//  Latency, counted from the start-sampled cycle 0 to the done cycle:
//   - MOV imm: 3.
//   - MOV reg / MVN: 5.
//   - ADD / AND: 6.
//   - CMP: 5.
//   - illegal: 2.
//  Back-to-back: start high in the done cycle is accepted; there is no idle bubble.
//  Reset (async, any state):
//   - state=WAIT, ir=0, done=illegal=0, busy=0.
//   - All enables deassert immediately.
//   - An in-flight instruction is abandoned: no write after reset asserts.
//  Arithmetic: none in this block; sign-extension only; widths exact, no truncation.
// STRUCTURE
//  Package dp_ctrl_pkg holds:
//   - state_t enum {WAIT, DECODE, GET_A, GET_B, ALU, WR_REG, WR_IMM}.
//   - Opcode/op localparams (OPC_MOV=3'b110, OPC_ALU=3'b101, OP_ADD..OP_MVN).
//   - Shift codes (SH_NONE, SH_LSL, SH_LSR, SH_ASR).
//  Sub-module instr_decoder (combinational):
//   - Inputs: ir.
//   - Outputs: field extract, sximm8/sximm5, class flags is_mov_imm/is_mov_reg/is_alu/is_cmp/is_illegal.
//  Top holds the ir register, the state register, the done/illegal flops and the output decode.
// TESTING
//  1 MOV imm:
//     start, instr=16'hD0FD (MOV R0,#-3) -> cycle 2: write=1, vsel=1, writenum=0, datapath_in=16'hFFFD.
//     Then done=1 in cycle 3.
//  2 ADD R2,R1,R0,LSL#1 (instr=16'hA148):
//     c2 readnum=1 loada; c3 readnum=0 loadb; c4 loadc, shift=01, ALUop=00.
//     c5 write, writenum=2, vsel=0; c6 done.
//  3 CMP R1,R1 (instr=16'hA901) -> c4: loadc=1, loads=1, ALUop=01; write never 1; done in c5.
//  4 illegal instr=16'hE000 -> done=1 and illegal=1 in c2; no load/write pulses.
//    A later MOV completes normally.
//  5 reset_n pulled low while in GET_B of an ADD:
//     - Immediately busy=0 and all enables=0.
//     - After release, no write occurs; a new start is accepted normally.
//  6 start held high across two MVN R3,R4 (instr=16'hB864):
//     - Second instr is accepted in the first done cycle; done pulses at c5 and c10.
//     - start toggled while busy changes nothing.

Source files
------------

// File: rtl/dp_ctrl_pkg.sv
// Shared types and encodings for the datapath controller.
package dp_ctrl_pkg;

    typedef enum logic [2:0] {
        WAIT,
        DECODE,
        GET_A,
        GET_B,
        ALU,
        WR_REG,
        WR_IMM
    } state_t;

    // Opcode field [15:13]
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // op field [12:11] under OPC_ALU
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MVN = 2'b11;

    // op field [12:11] under OPC_MOV
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;

    // Shifter codes
    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: field extraction, immediates, class flags.
module instr_decoder
    import dp_ctrl_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic [15:0]           ir,
    output logic [REG_ADDR_W-1:0] rn,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [REG_ADDR_W-1:0] rm,
    output logic [1:0]            sh,
    output logic [1:0]            op,
    output logic [DATA_W-1:0]     sximm8,
    output logic [DATA_W-1:0]     sximm5,
    output logic                  is_mov_imm,
    output logic                  is_mov_reg,
    output logic                  is_alu,
    output logic                  is_cmp,
    output logic                  is_mvn,
    output logic                  is_illegal
);

    logic [2:0] opc;

    assign opc    = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};
    assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};

    // Only MOV with op 00/10 and the four ALU ops are defined.
    assign is_mov_imm = (opc == OPC_MOV) && (op == OP_MOV_IMM);
    assign is_mov_reg = (opc == OPC_MOV) && (op == OP_MOV_REG);
    assign is_alu     = (opc == OPC_ALU);
    assign is_cmp     = is_alu && (op == OP_CMP);
    assign is_mvn     = is_alu && (op == OP_MVN);
    assign is_illegal = !(is_mov_imm || is_mov_reg || is_alu);

endmodule

// File: rtl/datapath_controller.sv
// Moore FSM sequencing the register/ALU datapath: read A, read B, ALU, write-back.
module datapath_controller
    import dp_ctrl_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [15:0]           instr,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal,
    output logic                  write,
    output logic                  vsel,
    output logic                  loada,
    output logic                  loadb,
    output logic                  loadc,
    output logic                  loads,
    output logic                  asel,
    output logic                  bsel,
    output logic [REG_ADDR_W-1:0] readnum,
    output logic [REG_ADDR_W-1:0] writenum,
    output logic [1:0]            shift,
    output logic [1:0]            ALUop,
    output logic [DATA_W-1:0]     datapath_in
);

    state_t                state, state_nxt;
    logic [15:0]           ir;
    logic [REG_ADDR_W-1:0] rn, rd, rm;
    logic [1:0]            sh, op;
    logic [DATA_W-1:0]     sximm8;
    logic                  is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn, is_illegal;

    instr_decoder #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_dec (
        .ir         (ir),
        .rn         (rn),
        .rd         (rd),
        .rm         (rm),
        .sh         (sh),
        .op         (op),
        .sximm8     (sximm8),
        .sximm5     (),
        .is_mov_imm (is_mov_imm),
        .is_mov_reg (is_mov_reg),
        .is_alu     (is_alu),
        .is_cmp     (is_cmp),
        .is_mvn     (is_mvn),
        .is_illegal (is_illegal)
    );

    // Static controls follow ir in every state; only the pulses depend on state.
    assign busy        = (state != WAIT);
    assign shift       = is_mov_imm ? SH_NONE : sh;
    assign ALUop       = is_alu ? op : OP_ADD;
    assign asel        = is_mov_reg || is_mvn;
    assign bsel        = 1'b0;
    assign datapath_in = sximm8;

    // State, instruction and completion flags; reset abandons any in-flight instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= WAIT;
            ir      <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state   <= state_nxt;
            if (state == WAIT && start)
                ir <= instr;
            done    <= (state != WAIT) && (state_nxt == WAIT);
            illegal <= (state == DECODE) && is_illegal;
        end
    end

    // Next-state and per-state control pulses.
    always_comb begin
        state_nxt = state;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        write     = 1'b0;
        vsel      = 1'b0;
        readnum   = rm;
        writenum  = '0;
        case (state)
            WAIT: begin
                if (start)
                    state_nxt = DECODE;
            end
            DECODE: begin
                if (is_mov_imm)
                    state_nxt = WR_IMM;
                else if (is_mov_reg || is_mvn)
                    state_nxt = GET_B;
                else if (is_alu)
                    state_nxt = GET_A;
                else
                    state_nxt = WAIT;
            end
            GET_A: begin
                readnum   = rn;
                loada     = 1'b1;
                state_nxt = GET_B;
            end
            GET_B: begin
                loadb     = 1'b1;
                state_nxt = ALU;
            end
            ALU: begin
                loadc     = 1'b1;
                loads     = is_cmp;
                state_nxt = is_cmp ? WAIT : WR_REG;
            end
            WR_REG: begin
                write     = 1'b1;
                writenum  = rd;
                state_nxt = WAIT;
            end
            WR_IMM: begin
                write     = 1'b1;
                vsel      = 1'b1;
                writenum  = rn;
                state_nxt = WAIT;
            end
            default: state_nxt = WAIT;
        endcase
    end

endmodule

// File: tb/tb_datapath_controller.sv
// Bench for datapath_controller: per-instruction phase-plan model plus directed literals.
module tb_datapath_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] instr;
    logic        busy, done, illegal, write, vsel, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_in;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;

    datapath_controller dut (
        .clk(clk), .reset_n(reset_n), .start(start), .instr(instr),
        .busy(busy), .done(done), .illegal(illegal), .write(write), .vsel(vsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .readnum(readnum), .writenum(writenum),
        .shift(shift), .ALUop(ALUop), .datapath_in(datapath_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One expected cycle of an instruction's life, as listed by phase.
    typedef struct packed {
        logic       busy, loada, loadb, loadc, loads, write, vsel, rd_rn, end_ill;
        logic [2:0] wnum;
    } step_t;

    step_t       plan[$];
    logic [15:0] mir = '0;
    logic        pend_done = 1'b0, pend_ill = 1'b0;

    function automatic step_t mk(input logic la, lb, lc, ls, w, v, rdrn, eill,
                                 input logic [2:0] wn);
        step_t s;
        s = '{busy:1'b1, loada:la, loadb:lb, loadc:lc, loads:ls, write:w, vsel:v,
              rd_rn:rdrn, end_ill:eill, wnum:wn};
        return s;
    endfunction

    // Expected cycle sequence after acceptance, straight from the instruction class.
    function automatic void build_plan(input logic [15:0] i);
        logic [2:0] opc;
        logic [1:0] op;
        opc = i[15:13];
        op  = i[12:11];
        plan.delete();
        if (opc == 3'b110 && op == 2'b10) begin
            plan.push_back(mk(0,0,0,0,0,0,0,0,3'd0));        // decode
            plan.push_back(mk(0,0,0,0,1,1,0,0,i[10:8]));     // write imm to Rn
        end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11)) begin
            plan.push_back(mk(0,0,0,0,0,0,0,0,3'd0));
            plan.push_back(mk(0,1,0,0,0,0,0,0,3'd0));        // read Rm
            plan.push_back(mk(0,0,1,0,0,0,0,0,3'd0));        // alu
            plan.push_back(mk(0,0,0,0,1,0,0,0,i[7:5]));      // write Rd
        end else if (opc == 3'b101) begin
            plan.push_back(mk(0,0,0,0,0,0,0,0,3'd0));
            plan.push_back(mk(1,0,0,0,0,0,1,0,3'd0));        // read Rn
            plan.push_back(mk(0,1,0,0,0,0,0,0,3'd0));
            plan.push_back(mk(0,0,1,(op == 2'b01),0,0,0,0,3'd0));
            if (op != 2'b01)
                plan.push_back(mk(0,0,0,0,1,0,0,0,i[7:5]));
        end else begin
            plan.push_back(mk(0,0,0,0,0,0,0,1,3'd0));        // decode finds it illegal
        end
    endfunction

    logic [36:0] ev, av;

    // Model step and full-output compare, once per cycle on the falling edge.
    always @(negedge clk) begin
        step_t      s;
        logic       d, il, mimm, mreg, mvn;
        logic [2:0] opc;
        logic [1:0] op;
        if (!reset_n) begin
            plan.delete();
            pend_done = 1'b0;
            pend_ill  = 1'b0;
            mir       = '0;
        end
        d  = 1'b0;
        il = 1'b0;
        if (plan.size() != 0) begin
            s = plan.pop_front();
            if (plan.size() == 0) begin
                pend_done = 1'b1;
                pend_ill  = s.end_ill;
            end
        end else begin
            s         = '0;
            d         = pend_done;
            il        = pend_ill;
            pend_done = 1'b0;
            pend_ill  = 1'b0;
        end
        opc  = mir[15:13];
        op   = mir[12:11];
        mimm = (opc == 3'b110) && (op == 2'b10);
        mreg = (opc == 3'b110) && (op == 2'b00);
        mvn  = (opc == 3'b101) && (op == 2'b11);
        ev = {s.busy, d, il, s.write, s.vsel, s.loada, s.loadb, s.loadc, s.loads,
              mreg | mvn, 1'b0, (s.rd_rn ? mir[10:8] : mir[2:0]), s.wnum,
              (mimm ? 2'b00 : mir[4:3]), ((opc == 3'b101) ? op : 2'b00),
              {{8{mir[7]}}, mir[7:0]}};
        av = {busy, done, illegal, write, vsel, loada, loadb, loadc, loads,
              asel, bsel, readnum, writenum, shift, ALUop, datapath_in};
        n_tests++;
        if (av !== ev) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t ir=%h got=%h exp=%h", $time, mir, av, ev);
        end
        if (reset_n && !s.busy && start) begin
            mir = instr;
            build_plan(instr);
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // Present one instruction for a single cycle; t0 marks the start-sampled cycle.
    task automatic issue(input logic [15:0] i);
        @(posedge clk); #1;
        start = 1'b1;
        instr = i;
        t0    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic at(input int k);
        while (cyc < t0 + k) @(negedge clk);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom % 5)
            0:       r[15:11] = 5'b11010;
            1:       r[15:11] = 5'b11000;
            2, 3:    r[15:13] = 3'b101;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        int wr_seen;
        reset_n = 1'b1;
        start   = 1'b0;
        instr   = '0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {14'd0, done, illegal}, 16'd0);
        chk("rst_dpin", datapath_in, 16'h0000);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // MOV R0,#-3
        issue(16'hD0FD);
        at(2);
        chk("t1_wr_vsel", {14'd0, write, vsel}, 16'h0003);
        chk("t1_wnum", {13'd0, writenum}, 16'd0);
        chk("t1_dpin", datapath_in, 16'hFFFD);
        at(3);
        chk("t1_done", {14'd0, done, busy}, 16'h0002);

        // ADD R2,R1,R0,LSL#1
        issue(16'hA148);
        at(2);
        chk("t2_c2", {9'd0, loada, loadb, 2'd0, readnum}, 16'h0041);
        at(3);
        chk("t2_c3", {9'd0, loada, loadb, 2'd0, readnum}, 16'h0020);
        at(4);
        chk("t2_c4", {9'd0, loadc, 2'd0, shift, ALUop}, 16'h0044);
        at(5);
        chk("t2_c5", {8'd0, write, vsel, 3'd0, writenum}, 16'h0082);
        at(6);
        chk("t2_done", {15'd0, done}, 16'd1);

        // CMP R1,R1
        issue(16'hA901);
        at(4);
        chk("t3_c4", {10'd0, loadc, loads, write, 1'b0, ALUop}, 16'h0031);
        at(5);
        chk("t3_done", {15'd0, done}, 16'd1);

        // Undefined opcode, then a normal MOV R3,#5
        issue(16'hE000);
        at(1);
        chk("t4_nopulse", {11'd0, loada, loadb, loadc, loads, write}, 16'd0);
        at(2);
        chk("t4_done_ill", {14'd0, done, illegal}, 16'h0003);
        issue(16'hD305);
        at(2);
        chk("t4_mov", {12'd0, write, writenum}, 16'h000B);
        chk("t4_dpin", datapath_in, 16'h0005);
        at(3);
        chk("t4_done", {14'd0, done, illegal}, 16'h0002);

        // Reset during GET_B of an ADD
        issue(16'hA148);
        at(3);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_busy", {15'd0, busy}, 16'd0);
        chk("t5_en", {9'd0, loada, loadb, loadc, loads, write, vsel, done}, 16'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        wr_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (write) wr_seen++;
        end
        chk("t5_nowrite", 16'(wr_seen), 16'd0);
        issue(16'hD0FD);
        at(2);
        chk("t5_new_wr", {15'd0, write}, 16'd1);
        at(3);
        chk("t5_new_done", {15'd0, done}, 16'd1);

        // Two MVN R3,R4 with start held; start toggling while busy
        @(posedge clk); #1;
        start = 1'b1;
        instr = 16'hB864;
        t0    = cyc;
        at(4);
        chk("t6_wr1", {12'd0, write, writenum}, 16'h000B);
        at(5);
        chk("t6_done1", {15'd0, done}, 16'd1);
        @(posedge clk); #1; start = 1'b1; instr = 16'hE000;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        at(9);
        chk("t6_wr2", {12'd0, write, writenum}, 16'h000B);
        chk("t6_c9", {14'd0, done, busy}, 16'h0001);
        at(10);
        chk("t6_done2", {14'd0, done, illegal}, 16'h0002);

        // Random traffic with occasional mid-cycle resets
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            instr = rand_instr();
            start = ($urandom % 3) == 0;
            if (c % 900 == 450) begin
                start = 1'b0;
                #2 reset_n = 1'b0;
                #3 reset_n = 1'b1;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
